// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 5-stage core: opcodes, field widths,
// immediate modifiers, OF/EX latch payload and operand-use decode.
package isa_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 4;
  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_MOD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_CMP  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_MOV  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_LSL  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_LSR  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ASR  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b01110;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b01111;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_BGT  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_B    = 5'b10010;
  localparam logic [OPC_W-1:0] OP_CALL = 5'b10011;
  localparam logic [OPC_W-1:0] OP_RET  = 5'b10100;

  localparam logic [XLEN-1:0]  NOP_IR = 32'h6800_0000;
  localparam logic [REG_W-1:0] RA_IDX = 4'd15;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_HIGH = 2'b10,
    IMM_RSVD = 2'b11
  } imm_mod_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] branch_target;
  } of_ex_t;

  // Instructions that actually consume read port 1.
  function automatic logic reads_src1(input logic [OPC_W-1:0] opc);
    return !(opc inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
  endfunction

  // Read port 2 is live for register-form ALU ops and for st (its rd).
  function automatic logic reads_src2(input logic [OPC_W-1:0] opc, input logic is_imm);
    if (opc == OP_ST) return 1'b1;
    return !is_imm && !(opc inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET,
                                    OP_NOT, OP_MOV});
  endfunction
endpackage

// File: rtl/of_operand_stage_if.sv
// Bundle between the OF stage and its surroundings: IF/OF inputs, register
// file read port, forwarding controls and the OF/EX latch outputs.
interface of_operand_stage_if;
  import isa_pkg::*;

  logic                 of_valid;
  logic [XLEN-1:0]      of_ir;
  logic [XLEN-1:0]      of_pc;
  logic [REG_W-1:0]     rf_rd_addr1;
  logic [REG_W-1:0]     rf_rd_addr2;
  logic [XLEN-1:0]      rf_rd_data1;
  logic [XLEN-1:0]      rf_rd_data2;
  logic [XLEN-1:0]      rw_result;
  logic                 is_RW_OF_conflict_src1;
  logic                 is_RW_OF_conflict_src2;
  logic                 branch_taken;
  logic                 of_stall;
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_ir;
  logic [XLEN-1:0]      ex_pc;
  logic [XLEN-1:0]      ex_a;
  logic [XLEN-1:0]      ex_b;
  logic [XLEN-1:0]      ex_op2;
  logic [XLEN-1:0]      ex_branch_target;

  modport master (
    output of_valid, of_ir, of_pc, rf_rd_data1, rf_rd_data2, rw_result,
           is_RW_OF_conflict_src1, is_RW_OF_conflict_src2, branch_taken,
    input  rf_rd_addr1, rf_rd_addr2, of_stall, ex_valid, ex_ir, ex_pc,
           ex_a, ex_b, ex_op2, ex_branch_target
  );

  modport slave (
    input  of_valid, of_ir, of_pc, rf_rd_data1, rf_rd_data2, rw_result,
           is_RW_OF_conflict_src1, is_RW_OF_conflict_src2, branch_taken,
    output rf_rd_addr1, rf_rd_addr2, of_stall, ex_valid, ex_ir, ex_pc,
           ex_a, ex_b, ex_op2, ex_branch_target
  );
endinterface

// File: rtl/of_operand_stage_imm_gen.sv
// Combinational immediate expansion and PC-relative branch target.
module imm_gen
  import isa_pkg::*;
(
  input  logic [26:0]     ir_lo,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm_c,
  output logic [XLEN-1:0] branch_target_c
);
  logic [15:0] imm16;
  assign imm16 = ir_lo[15:0];

  // Modifier 11 is reserved and decodes like plain sign extension.
  always_comb begin
    imm_c = {{16{imm16[15]}}, imm16};
    case (imm_mod_e'(ir_lo[17:16]))
      IMM_ZEXT: imm_c = {16'h0000, imm16};
      IMM_HIGH: imm_c = {imm16, 16'h0000};
      default:  imm_c = {{16{imm16[15]}}, imm16};
    endcase
  end

  assign branch_target_c = pc + {{3{ir_lo[26]}}, ir_lo, 2'b00};
endmodule

// File: rtl/of_operand_stage.sv
// Operand-fetch stage: register read addressing, RW->OF forwarding,
// load-use interlock and the OF/EX pipeline latch.
module of_operand_stage
  import isa_pkg::*;
(
  input  logic clk,
  input  logic reset,
  of_operand_stage_if.slave bus
);
  localparam of_ex_t EX_RESET = '{valid: 1'b0, ir: NOP_IR, pc: '0, a: '0, b: '0,
                                  op2: '0, branch_target: '0};

  logic [OPC_W-1:0] opc;
  logic             is_imm;
  logic [XLEN-1:0]  imm_c;
  logic [XLEN-1:0]  branch_target_c;
  logic [XLEN-1:0]  op_a_c;
  logic [XLEN-1:0]  op_b_c;
  logic [REG_W-1:0] ld_dest;
  logic             ex_is_ld;
  logic             src_hit;
  logic             stall_c;
  of_ex_t           ex_d;
  of_ex_t           ex_q;

  assign opc    = bus.of_ir[31:27];
  assign is_imm = bus.of_ir[26];

  assign bus.rf_rd_addr1 = (opc == OP_RET) ? RA_IDX : bus.of_ir[21:18];
  assign bus.rf_rd_addr2 = (opc == OP_ST) ? bus.of_ir[25:22] : bus.of_ir[17:14];

  imm_gen u_imm_gen (
    .ir_lo           (bus.of_ir[26:0]),
    .pc              (bus.of_pc),
    .imm_c           (imm_c),
    .branch_target_c (branch_target_c)
  );

  assign op_a_c = bus.is_RW_OF_conflict_src1 ? bus.rw_result : bus.rf_rd_data1;
  assign op_b_c = bus.is_RW_OF_conflict_src2 ? bus.rw_result : bus.rf_rd_data2;

  // Load in EX whose destination is a register OF really reads: one bubble.
  assign ld_dest  = ex_q.ir[25:22];
  assign ex_is_ld = ex_q.valid && (ex_q.ir[31:27] == OP_LD);
  assign src_hit  = (reads_src1(opc) && (ld_dest == bus.rf_rd_addr1)) ||
                    (reads_src2(opc, is_imm) && (ld_dest == bus.rf_rd_addr2));
  assign stall_c  = ex_is_ld && bus.of_valid && !bus.branch_taken && src_hit;
  assign bus.of_stall = stall_c;

  always_comb begin
    ex_d               = ex_q;
    ex_d.valid         = 1'b1;
    ex_d.ir            = bus.of_ir;
    ex_d.pc            = bus.of_pc;
    ex_d.a             = op_a_c;
    ex_d.b             = op_b_c;
    ex_d.op2           = is_imm ? imm_c : op_b_c;
    ex_d.branch_target = branch_target_c;
  end

  // Bubbles only clear valid/ir; EX ignores the remaining held fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= EX_RESET;
    end else if (bus.branch_taken || stall_c || !bus.of_valid) begin
      ex_q.valid <= 1'b0;
      ex_q.ir    <= NOP_IR;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid         = ex_q.valid;
  assign bus.ex_ir            = ex_q.ir;
  assign bus.ex_pc            = ex_q.pc;
  assign bus.ex_a             = ex_q.a;
  assign bus.ex_b             = ex_q.b;
  assign bus.ex_op2           = ex_q.op2;
  assign bus.ex_branch_target = ex_q.branch_target;
endmodule

// File: tb/tb_of_operand_stage.sv
// Self-checking bench for of_operand_stage: directed table, hand-written
// load-use / flush / reset sequences, then randomized traffic against a model.
module tb_of_operand_stage;
  localparam logic [31:0] NOP = 32'h6800_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  of_operand_stage_if bus ();

  of_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] rw;
    logic        c1;
    logic        c2;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_op2;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[7];

  // Reference model state of the OF/EX latch.
  logic        m_valid;
  logic [31:0] m_ir, m_pc, m_a, m_b, m_op2, m_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] rw, input logic c1, input logic c2,
                       input logic bt);
    bus.of_valid = v;
    bus.of_ir = ir;
    bus.of_pc = pc;
    bus.rf_rd_data1 = d1;
    bus.rf_rd_data2 = d2;
    bus.rw_result = rw;
    bus.is_RW_OF_conflict_src1 = c1;
    bus.is_RW_OF_conflict_src2 = c2;
    bus.branch_taken = bt;
  endtask

  task automatic chk_latch(input string tag, input logic valid, input logic [31:0] ir,
                           input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] op2,
                           input logic [31:0] tgt);
    chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(valid));
    chk({tag, ".ex_ir"}, bus.ex_ir, ir);
    chk({tag, ".ex_pc"}, bus.ex_pc, pc);
    chk({tag, ".ex_a"}, bus.ex_a, a);
    chk({tag, ".ex_b"}, bus.ex_b, b);
    chk({tag, ".ex_op2"}, bus.ex_op2, op2);
    chk({tag, ".ex_tgt"}, bus.ex_branch_target, tgt);
  endtask

  function automatic logic [31:0] model_imm(input logic [31:0] ir);
    longint u;
    u = longint'(ir[15:0]);
    case (ir[17:16])
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'((u >= 32768) ? u - 65536 : u);
    endcase
  endfunction

  function automatic logic [31:0] model_tgt(input logic [31:0] ir, input logic [31:0] pc);
    longint off;
    off = longint'(ir[26:0]);
    if (off >= 67108864) off = off - 134217728;
    return 32'(longint'(pc) + off * 4);
  endfunction

  // Which source registers an opcode consumes, from the instruction set rules.
  function automatic bit uses_a(input int opc);
    return !(opc == 13 || opc == 18 || opc == 16 || opc == 17 || opc == 19 ||
             opc == 8 || opc == 9);
  endfunction

  function automatic bit uses_b(input int opc, input bit imm);
    if (opc == 15) return 1'b1;
    if (imm) return 1'b0;
    return !(opc == 13 || opc == 18 || opc == 16 || opc == 17 || opc == 19 ||
             opc == 20 || opc == 8 || opc == 9);
  endfunction

  function automatic int m_addr1(input logic [31:0] ir);
    return (int'(ir[31:27]) == 20) ? 15 : int'(ir[21:18]);
  endfunction

  function automatic int m_addr2(input logic [31:0] ir);
    return (int'(ir[31:27]) == 15) ? int'(ir[25:22]) : int'(ir[17:14]);
  endfunction

  function automatic bit model_stall(input logic v, input logic [31:0] ir, input logic bt);
    int dest;
    int opc;
    if (!m_valid || int'(m_ir[31:27]) != 14 || !v || bt) return 1'b0;
    dest = int'(m_ir[25:22]);
    opc = int'(ir[31:27]);
    return (uses_a(opc) && dest == m_addr1(ir)) ||
           (uses_b(opc, ir[26]) && dest == m_addr2(ir));
  endfunction

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] r_ir;
    logic        r_v, r_c1, r_c2, r_bt;
    logic [31:0] r_d1, r_d2, r_rw, r_pc;
    bit          e_stall;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    drive(1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // valid  ir            pc         d1         d2         rw          c1 c2 | e_valid e_pc  e_a  e_b  e_op2  e_tgt
    vecs[0] = '{1'b1, 32'h0048C000, 32'h40, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0,
                1'b1, 32'h40, 32'd5, 32'd7, 32'd7, 32'h01230040};
    vecs[1] = '{1'b1, 32'h0448FFFF, 32'h44, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0,
                1'b1, 32'h44, 32'd1, 32'd2, 32'hFFFFFFFF, 32'hF1240040};
    vecs[2] = '{1'b1, 32'h0449FFFF, 32'h48, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0,
                1'b1, 32'h48, 32'd3, 32'd4, 32'h0000FFFF, 32'hF1280044};
    vecs[3] = '{1'b1, 32'h044AFFFF, 32'h4C, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0,
                1'b1, 32'h4C, 32'd3, 32'd4, 32'hFFFF0000, 32'hF12C0048};
    vecs[4] = '{1'b1, 32'h0048C000, 32'h50, 32'd0, 32'd9, 32'hDEADBEEF, 1'b1, 1'b0,
                1'b1, 32'h50, 32'hDEADBEEF, 32'd9, 32'd9, 32'h01230050};
    vecs[5] = '{1'b1, 32'h90000003, 32'h100, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0,
                1'b1, 32'h100, 32'd0, 32'd0, 32'd0, 32'h10C};
    vecs[6] = '{1'b0, 32'h0048C000, 32'h200, 32'h11, 32'h22, 32'h55, 1'b1, 1'b1,
                1'b0, 32'h100, 32'd0, 32'd0, 32'd0, 32'h10C};

    #12;
    chk_latch("reset", 1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("reset.of_stall", 32'(bus.of_stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].ir, vecs[i].pc, vecs[i].d1, vecs[i].d2, vecs[i].rw,
            vecs[i].c1, vecs[i].c2, 1'b0);
      #1;
      chk($sformatf("vec%0d.of_stall", i), 32'(bus.of_stall), 32'h0);
      tick();
      chk_latch($sformatf("vec%0d", i), vecs[i].e_valid,
                vecs[i].e_valid ? vecs[i].ir : NOP, vecs[i].e_pc, vecs[i].e_a,
                vecs[i].e_b, vecs[i].e_op2, vecs[i].e_tgt);
    end

    // ld r4,0[r2] then dependent add r5,r4,r1: exactly one bubble.
    drive(1'b1, 32'h75080000, 32'h200, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu.addr1", 32'(bus.rf_rd_addr1), 32'd2);
    tick();
    chk("lu.ld_latched", bus.ex_ir, 32'h75080000);
    drive(1'b1, 32'h01504000, 32'h204, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu.stall", 32'(bus.of_stall), 32'h1);
    tick();
    chk("lu.bubble_valid", 32'(bus.ex_valid), 32'h0);
    chk("lu.bubble_ir", bus.ex_ir, NOP);
    chk("lu.release", 32'(bus.of_stall), 32'h0);
    tick();
    chk("lu.add_valid", 32'(bus.ex_valid), 32'h1);
    chk("lu.add_ir", bus.ex_ir, 32'h01504000);
    chk("lu.add_pc", bus.ex_pc, 32'h204);

    // Flush wins over a pending load-use stall.
    drive(1'b1, 32'h75080000, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h01504000, 32'h304, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush.pre_stall", 32'(bus.of_stall), 32'h1);
    bus.branch_taken = 1'b1;
    #1;
    chk("flush.stall", 32'(bus.of_stall), 32'h0);
    tick();
    chk("flush.valid", 32'(bus.ex_valid), 32'h0);
    chk("flush.ir", bus.ex_ir, NOP);

    // Asynchronous reset between edges, then first load after release.
    drive(1'b1, 32'h0048C000, 32'h400, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("areset.pre_valid", 32'(bus.ex_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk_latch("areset", 1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    reset = 1'b0;
    tick();
    chk("areset.reload_valid", 32'(bus.ex_valid), 32'h1);
    chk("areset.reload_pc", bus.ex_pc, 32'h400);

    // Randomized traffic against the reference model, starting from reset.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_valid = 1'b0; m_ir = NOP; m_pc = '0; m_a = '0; m_b = '0; m_op2 = '0; m_tgt = '0;
    for (int n = 0; n < 3000; n++) begin
      r_ir = $urandom;
      r_ir[31:27] = ($urandom_range(0, 3) == 0) ? 5'd14 : 5'($urandom_range(0, 20));
      r_ir[25:22] = pick_reg();
      r_ir[21:18] = pick_reg();
      r_ir[17:14] = pick_reg();
      r_v  = ($urandom_range(0, 99) < 85);
      r_bt = ($urandom_range(0, 99) < 10);
      r_c1 = ($urandom_range(0, 99) < 25);
      r_c2 = ($urandom_range(0, 99) < 25);
      r_pc = $urandom & 32'hFFFF_FFFC;
      r_d1 = $urandom;
      r_d2 = $urandom;
      r_rw = $urandom;
      drive(r_v, r_ir, r_pc, r_d1, r_d2, r_rw, r_c1, r_c2, r_bt);
      #1;
      e_stall = model_stall(r_v, r_ir, r_bt);
      chk("rnd.addr1", 32'(bus.rf_rd_addr1), 32'(m_addr1(r_ir)));
      chk("rnd.addr2", 32'(bus.rf_rd_addr2), 32'(m_addr2(r_ir)));
      chk("rnd.of_stall", 32'(bus.of_stall), 32'(e_stall));
      if (r_bt || e_stall || !r_v) begin
        m_valid = 1'b0;
        m_ir = NOP;
      end else begin
        m_valid = 1'b1;
        m_ir = r_ir;
        m_pc = r_pc;
        m_a = r_c1 ? r_rw : r_d1;
        m_b = r_c2 ? r_rw : r_d2;
        m_op2 = r_ir[26] ? model_imm(r_ir) : m_b;
        m_tgt = model_tgt(r_ir, r_pc);
      end
      tick();
      chk_latch("rnd", m_valid, m_ir, m_pc, m_a, m_b, m_op2, m_tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
